led_shift_ctrl: RTL

//  Sequences the serial load of the LED driver chains: fetches one word per band from the frame

---
 rtl/led_shift_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/led_shift_ctrl.sv
// LED driver chain loader: fetches one word per step from the frame buffer and shifts every band
// MSB-first onto parallel SOUT lines with a generated SCLK and one LAT pulse per word.
module led_shift_ctrl #(
   parameter int NB_LED_BAND = 20,
   parameter int WORD_WIDTH  = 48,
   parameter int NB_WORDS    = 16,
   parameter int CLK_DIV     = 2
) (
   input  logic                              clk,
   input  logic                              nrst,
   input  logic                              start,
   output logic                              busy,
   output logic                              done,
   output logic                              rd_req,
   output logic [$clog2(NB_WORDS)-1:0]       rd_addr,
   input  logic [NB_LED_BAND*WORD_WIDTH-1:0] rd_data,
   input  logic                              hps_override,
   input  logic [NB_LED_BAND-1:0]            hps_SOUT,
   input  logic                              hps_SCLK,
   input  logic                              hps_LAT,
   output logic [NB_LED_BAND-1:0]            SOUT,
   output logic                              SCLK,
   output logic                              LAT
);

   localparam int AW = $clog2(NB_WORDS);
   localparam int BW = $clog2(WORD_WIDTH);
   localparam int DW = $clog2(CLK_DIV + 1);
   localparam logic [AW-1:0] LAST_WORD = AW'(NB_WORDS - 1);
   localparam logic [BW-1:0] MSB_BIT   = BW'(WORD_WIDTH - 1);
   localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_SHIFT,
      S_LATCH
   } state_t;

   state_t                          state;
   state_t                          state_nxt;
   logic [AW-1:0]                   word;
   logic [BW-1:0]                   bit_cnt;
   logic [DW-1:0]                   div_cnt;
   logic                            sclk_hi;
   logic [NB_LED_BAND*WORD_WIDTH-1:0] shreg;
   logic [NB_LED_BAND-1:0]          sout_r;
   logic                            sclk_r;
   logic                            lat_r;
   logic [NB_LED_BAND-1:0]          load_msb;
   logic [NB_LED_BAND-1:0]          next_msb;
   logic                            accept;
   logic                            div_last;
   logic                            bit_adv;
   logic                            seq_end;

   // Each band's current bit sits at the top of its slice; the flat shift below never
   // carries a neighbour's bit far enough to reach that position within one word.
   for (genvar k = 0; k < NB_LED_BAND; k++) begin : g_band
      assign load_msb[k] = rd_data[k*WORD_WIDTH + WORD_WIDTH - 1];
      assign next_msb[k] = shreg[k*WORD_WIDTH + WORD_WIDTH - 2];
   end

   // A start coinciding with the done pulse is dropped so the completed sequence is seen first.
   assign accept   = (state == S_IDLE) && start && !done && !hps_override;
   assign div_last = (div_cnt == DIV_LAST);
   assign bit_adv  = (state == S_SHIFT) && div_last && sclk_hi;
   assign seq_end  = (state == S_LATCH) && div_last && (word == LAST_WORD) && !hps_override;

   assign busy    = (state != S_IDLE);
   assign rd_req  = (state == S_FETCH) && !hps_override;
   assign rd_addr = word;

   assign SOUT = hps_override ? hps_SOUT : sout_r;
   assign SCLK = hps_override ? hps_SCLK : sclk_r;
   assign LAT  = hps_override ? hps_LAT  : lat_r;

   always_ff @(posedge clk) begin
      if (!nrst) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (hps_override) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (accept) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_SHIFT;
            S_SHIFT: if (bit_adv && (bit_cnt == '0)) state_nxt = S_LATCH;
            S_LATCH: if (div_last) state_nxt = (word == LAST_WORD) ? S_IDLE : S_FETCH;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         word    <= '0;
         bit_cnt <= '0;
         div_cnt <= '0;
         sclk_hi <= 1'b0;
         sout_r  <= '0;
         sclk_r  <= 1'b0;
         lat_r   <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= seq_end;
         if (hps_override) begin
            sout_r  <= '0;
            sclk_r  <= 1'b0;
            lat_r   <= 1'b0;
            sclk_hi <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (accept) word <= '0;
               end
               S_LOAD: begin
                  bit_cnt <= MSB_BIT;
                  div_cnt <= '0;
                  sclk_hi <= 1'b0;
                  sclk_r  <= 1'b0;
                  sout_r  <= load_msb;
               end
               S_SHIFT: begin
                  if (div_last) begin
                     div_cnt <= '0;
                     if (!sclk_hi) begin
                        sclk_hi <= 1'b1;
                        sclk_r  <= 1'b1;
                     end else begin
                        sclk_hi <= 1'b0;
                        sclk_r  <= 1'b0;
                        if (bit_cnt == '0) begin
                           lat_r <= 1'b1;
                        end else begin
                           bit_cnt <= bit_cnt - 1'b1;
                           sout_r  <= next_msb;
                        end
                     end
                  end else begin
                     div_cnt <= div_cnt + 1'b1;
                  end
               end
               S_LATCH: begin
                  if (div_last) begin
                     div_cnt <= '0;
                     lat_r   <= 1'b0;
                     if (word != LAST_WORD) word <= word + 1'b1;
                  end else begin
                     div_cnt <= div_cnt + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == S_LOAD)                     shreg <= rd_data;
      else if (bit_adv && (bit_cnt != '0))     shreg <= shreg << 1;
   end

endmodule
